// File: rtl/mem_store_buffer.sv
// mem_store_buffer: word-granular store buffer between MEM stage and the
// single-port data memory. Buffers stores in a circular FIFO, drains one per
// idle memory cycle, and forwards the youngest pending value to hitting loads.
// Optional feature macro: STBUF_COALESCE_EN (in-place merge of same-address
// stores into a non-draining entry).
module mem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [31:0]   ld_data,
  output logic          ld_hit,
  output logic          empty,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  input  logic [31:0]   dm_dout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic drain_c;
  logic push_c;
  logic match_c;
  logic [PW-1:0] match_idx_c;

  // Memory port arbitration: loads own the port, otherwise drain the head.
  always_comb begin
    drain_c = (count_q != '0) && !ld_valid;
    empty   = (count_q == '0);
    dm_we   = drain_c;
    dm_addr = ld_valid ? ld_addr : addr_q[head_q];
    dm_din  = data_q[head_q];
  end

  // Load forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = dm_dout;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (ld_valid && (CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[head_q + PW'(k)];
      end
    end
  end

`ifdef STBUF_COALESCE_EN
  // Coalesce lookup: youngest matching entry, skipping the head if it drains now.
  always_comb begin
    match_c     = 1'b0;
    match_idx_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == st_addr) &&
          !(drain_c && (k == 0))) begin
        match_c     = 1'b1;
        match_idx_c = head_q + PW'(k);
      end
    end
  end

  // Store acceptance with coalescing: a merge never needs a free slot.
  always_comb begin
    st_ready = !ld_valid && (match_c || (count_q < CW'(DEPTH)) || drain_c);
    push_c   = st_valid && st_ready && !match_c;
  end
`else
  // No coalescing: no lookup needed.
  always_comb begin
    match_c     = 1'b0;
    match_idx_c = '0;
  end

  // Store acceptance: a full buffer still accepts when the head drains this edge.
  always_comb begin
    st_ready = !ld_valid && ((count_q < CW'(DEPTH)) || drain_c);
    push_c   = st_valid && st_ready;
  end
`endif

  // Next-state for FIFO storage, pointers and occupancy.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PW'(1);
    end
    if (st_valid && st_ready && match_c) begin
      data_d[match_idx_c] = st_data;
    end
    if (drain_c) begin
      head_d = head_q + PW'(1);
    end
    case ({push_c, drain_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards all pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
